intc27_request_sequencer: RTL

Sequential requester/acknowledge side of the 27-channel, three-bus priority interrupt encoder. It latches interrupt requests into pending bits and drives the registered per-bus request vectors into the combinational encoder. It then samples the returned bus-grant flags and channel code, offers the winning interrupt to a service agent over a valid/ready handshake, and pulses a one-hot acknowledge that clears the serviced pending bit.

---
 rtl/intc27_pkg.sv | 20 ++
 rtl/intc27_pending_bank.sv | 43 ++++
 rtl/intc27_request_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/intc27_pkg.sv
// Shared types and helpers for the 27-channel, three-bus interrupt request sequencer.
package intc27_pkg;

  localparam int unsigned NCH  = 9;
  localparam int unsigned NBUS = 3;
  localparam int unsigned ID_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_OFFER,
    ST_ACK
  } intc27_state_t;

  // Flat interrupt id: bus * NCH + channel.
  function automatic logic [ID_W-1:0] intc27_id(input logic [1:0] bus, input logic [3:0] chan);
    return ID_W'(bus) * ID_W'(NCH) + ID_W'(chan);
  endfunction

endpackage

// File: rtl/intc27_pending_bank.sv
// Set-priority pending flops plus the masked request registers that freeze outside IDLE.
module intc27_pending_bank #(
  parameter int unsigned NCH  = 9,
  parameter int unsigned NBUS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NBUS*NCH-1:0]           src_req,
  input  logic [NBUS*NCH-1:0]           clr,
  input  logic [NCH-1:0]                ch_en,
  input  logic                          load,
  output logic                          req_nxt_any,
  output logic [NBUS*NCH-1:0]           pend,
  output logic [NBUS-1:0][NCH-1:0]      req_vec
);

  logic [NBUS*NCH-1:0]      pend_q, pend_d;
  logic [NBUS-1:0][NCH-1:0] req_q, req_d, masked;

  always_comb begin
    // Set is applied after clear so a same-cycle re-request survives the acknowledge.
    pend_d = (pend_q & ~clr) | src_req;
    for (int unsigned b = 0; b < NBUS; b++) begin
      masked[b] = pend_q[b*NCH +: NCH] & ch_en;
    end
    req_d = load ? masked : req_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      req_q  <= '0;
    end else begin
      pend_q <= pend_d;
      req_q  <= req_d;
    end
  end

  assign req_nxt_any = |masked;
  assign pend        = pend_q;
  assign req_vec     = req_q;

endmodule

// File: rtl/intc27_request_sequencer.sv
// Request/acknowledge sequencer: freezes requests, samples the encoder grant, offers and acknowledges.
module intc27_request_sequencer #(
  parameter int unsigned NCH     = intc27_pkg::NCH,
  parameter int unsigned NBUS    = intc27_pkg::NBUS,
  parameter int unsigned ENC_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NBUS*NCH-1:0]           src_req,
  input  logic [NCH-1:0]                ch_en,
  output logic [NCH-1:0]                req_a,
  output logic [NCH-1:0]                req_b,
  output logic [NCH-1:0]                req_c,
  input  logic [NBUS-1:0]               grant_bus,
  input  logic [3:0]                    grant_chan,
  output logic                          svc_valid,
  input  logic                          svc_ready,
  output logic [intc27_pkg::ID_W-1:0]   svc_id,
  output logic [NBUS*NCH-1:0]           ack,
  output logic                          err
);

  import intc27_pkg::*;

  localparam int unsigned CNT_W = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;

  intc27_state_t            state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ID_W-1:0]          svc_id_q, svc_id_d;
  logic                     err_q, err_d;
  logic                     req_nxt_any;
  logic [NBUS*NCH-1:0]      pend;
  logic [NBUS-1:0][NCH-1:0] req_vec;
  logic [1:0]               win_bus;
  logic                     win_found;
  logic [NCH-1:0]           win_vec;
  logic                     win_hit;

  intc27_pending_bank #(.NCH(NCH), .NBUS(NBUS)) u_bank (
    .clk         (clk),
    .rst         (rst),
    .src_req     (src_req),
    .clr         (ack),
    .ch_en       (ch_en),
    .load        (state_q == ST_IDLE),
    .req_nxt_any (req_nxt_any),
    .pend        (pend),
    .req_vec     (req_vec)
  );

  always_comb begin
    win_bus   = '0;
    win_found = 1'b0;
    for (int unsigned b = 0; b < NBUS; b++) begin
      if (grant_bus[b] && !win_found) begin
        win_bus   = 2'(b);
        win_found = 1'b1;
      end
    end
    win_vec = req_vec[win_bus];
    win_hit = (grant_chan <= 4'(NCH - 1)) && win_vec[grant_chan];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    svc_id_d = svc_id_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_nxt_any) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(ENC_LAT - 1)) begin
          if (!win_found) begin
            state_d = ST_IDLE;
          end else if (!win_hit) begin
            // Out-of-range code and a grant for an unrequested bit are both encoder faults.
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            svc_id_d = intc27_id(win_bus, grant_chan);
            state_d  = ST_OFFER;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OFFER: begin
        if (svc_ready) state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      svc_id_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      svc_id_q <= svc_id_d;
      err_q    <= err_d;
    end
  end

  assign req_a     = req_vec[0];
  assign req_b     = req_vec[1];
  assign req_c     = req_vec[2];
  assign svc_valid = (state_q == ST_OFFER);
  assign svc_id    = svc_id_q;
  assign ack       = (state_q == ST_ACK) ? ((NBUS*NCH)'(1) << svc_id_q) : '0;
  assign err       = err_q;

endmodule
